// File: rtl/ray_pkg.sv
// Shared widths, the "no intersection" code and the scheduler state encoding.
package ray_pkg;

  localparam int RAY_INIT_W = 28;
  localparam int RAY_DIR_W  = 31;
  localparam int OBJ_W      = 56;
  localparam int T_W        = 10;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    CMP,
    DONE
  } state_t;

endpackage

// File: rtl/ray_box_scheduler_if.sv
// Ray request, object RAM, box unit and result signals of the box scheduler.
// The scheduler uses the master modport; its environment uses the slave modport.
interface ray_box_scheduler_if import ray_pkg::*; #(
  parameter int OBJ_AW = 4
);

  logic                  ray_valid;
  logic                  ray_ready;
  logic [RAY_INIT_W-1:0] ray_init;
  logic [RAY_DIR_W-1:0]  ray_dir;
  logic [OBJ_AW:0]       num_objects;

  logic                  obj_rd_en;
  logic [OBJ_AW-1:0]     obj_addr;
  logic [OBJ_W-1:0]      obj_data;

  logic                  box_rst;
  logic [RAY_INIT_W-1:0] box_init;
  logic [RAY_DIR_W-1:0]  box_dir;
  logic [OBJ_W-1:0]      box_object;
  logic [T_W-1:0]        box_t;

  logic                  res_valid;
  logic                  res_ready;
  logic [T_W-1:0]        res_t;
  logic                  res_hit;
  logic [OBJ_AW-1:0]     res_obj_id;

  modport master (
    input  ray_valid, ray_init, ray_dir, num_objects,
    input  obj_data, box_t, res_ready,
    output ray_ready, obj_rd_en, obj_addr,
    output box_rst, box_init, box_dir, box_object,
    output res_valid, res_t, res_hit, res_obj_id
  );

  modport slave (
    output ray_valid, ray_init, ray_dir, num_objects,
    output obj_data, box_t, res_ready,
    input  ray_ready, obj_rd_en, obj_addr,
    input  box_rst, box_init, box_dir, box_object,
    input  res_valid, res_t, res_hit, res_obj_id
  );

endinterface

// File: rtl/ray_box_scheduler_nearest_hit_tracker.sv
// Keeps the nearest hit seen so far for the current ray.
// A candidate replaces the best only when it is a real hit and strictly nearer,
// so among equal distances the first (lowest index) object wins.
module nearest_hit_tracker #(
  parameter int                        OBJ_AW = 4,
  parameter logic [ray_pkg::T_W-1:0]   MISS_T = ray_pkg::T_MISS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    upd_en,
  input  logic [ray_pkg::T_W-1:0] cand_t,
  input  logic [OBJ_AW-1:0]       cand_id,
  output logic [ray_pkg::T_W-1:0] best_t,
  output logic [OBJ_AW-1:0]       best_id,
  output logic                    hit
);

  logic take;

  assign take = upd_en && (cand_t != MISS_T) && (cand_t < best_t);

  // best distance / index registers, cleared per ray
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_t  <= MISS_T;
      best_id <= '0;
      hit     <= 1'b0;
    end else if (take) begin
      best_t  <= cand_t;
      best_id <= cand_id;
      hit     <= 1'b1;
    end
  end

endmodule

// File: rtl/ray_box_scheduler.sv
// Walks one box-intersection unit over an object list held in a sync-read RAM,
// one ray at a time, and returns the nearest hit on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a ray; ray_ready high
// FETCH | object RAM read of entry idx
// LOAD  | capture RAM word into box_object; box unit still in restart
// RUN   | box unit running; latency down-counter active
// CMP   | box_t valid; fold it into the nearest-hit tracker
// DONE  | result presented until res_valid & res_ready
module ray_box_scheduler #(
  parameter int                      OBJ_AW  = 4,
  parameter int                      BOX_LAT = 32,
  parameter logic [ray_pkg::T_W-1:0] T_MISS  = ray_pkg::T_MISS
) (
  input  logic                 clk,
  input  logic                 rst,
  ray_box_scheduler_if.master  bus
);

  import ray_pkg::*;

  localparam int              CNT_W   = $clog2(BOX_LAT + 1);
  localparam logic [OBJ_AW:0] MAX_OBJ = {1'b1, {OBJ_AW{1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [OBJ_AW:0]   idx;
  logic [OBJ_AW:0]   n_obj;
  logic [OBJ_AW:0]   n_clamp;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_obj;
  logic              res_valid_q;
  logic              res_take;

  assign n_clamp  = (bus.num_objects > MAX_OBJ) ? MAX_OBJ : bus.num_objects;
  assign accept   = bus.ray_valid && (state == IDLE);
  assign last_obj = (idx == n_obj - 1'b1);
  assign res_take = res_valid_q && bus.res_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (n_clamp == '0) ? DONE : FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD:  state_nxt = RUN;
      RUN: begin
        if (cnt == '0) state_nxt = CMP;
      end
      CMP: state_nxt = last_obj ? DONE : FETCH;
      DONE: begin
        if (res_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ray parameters and clamped object count, captured only at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.box_init <= '0;
      bus.box_dir  <= '0;
      n_obj        <= '0;
    end else if (accept) begin
      bus.box_init <= bus.ray_init;
      bus.box_dir  <= bus.ray_dir;
      n_obj        <= n_clamp;
    end
  end

  // object index; one bit wider than the address so a full list cannot wrap
  always_ff @(posedge clk) begin
    if (rst || accept)             idx <= '0;
    else if (state == CMP && !last_obj) idx <= idx + 1'b1;
  end

  // object word captured from the RAM the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (rst)                 bus.box_object <= '0;
    else if (state == LOAD)  bus.box_object <= bus.obj_data;
  end

  // box latency down-counter; terminal count at zero ends RUN
  always_ff @(posedge clk) begin
    if (rst)                            cnt <= '0;
    else if (state == LOAD)             cnt <= CNT_W'(BOX_LAT - 1);
    else if (state == RUN && cnt != '0) cnt <= cnt - 1'b1;
  end

  // result valid rises one cycle after entering DONE and drops on the handshake
  always_ff @(posedge clk) begin
    if (rst)                res_valid_q <= 1'b0;
    else if (state == DONE) res_valid_q <= !res_take;
    else                    res_valid_q <= 1'b0;
  end

  nearest_hit_tracker #(
    .OBJ_AW (OBJ_AW),
    .MISS_T (T_MISS)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .upd_en  (state == CMP),
    .cand_t  (bus.box_t),
    .cand_id (idx[OBJ_AW-1:0]),
    .best_t  (bus.res_t),
    .best_id (bus.res_obj_id),
    .hit     (bus.res_hit)
  );

  // reset is folded in so the box unit is held in restart and nothing is
  // requested during the reset cycle itself, whatever state it interrupts
  assign bus.ray_ready = !rst && (state == IDLE);
  assign bus.obj_rd_en = !rst && (state == FETCH);
  assign bus.obj_addr  = (state == FETCH) ? idx[OBJ_AW-1:0] : '0;
  assign bus.box_rst   = rst || !((state == RUN) || (state == CMP));
  assign bus.res_valid = res_valid_q;

endmodule
